// File: rtl/cic_pkg.sv
// Shared sizing helpers and parameter-range checks for the CIC decimator family.
package cic_pkg;

  function automatic int acc_w(input int order, input int r_log2);
    return order * r_log2 + 1;
  endfunction

  // Largest representable output before scaling; only R^ORDER itself exceeds it.
  function automatic logic [63:0] sat_limit(input int order, input int r_log2);
    return (64'd1 << (order * r_log2)) - 64'd1;
  endfunction

  function automatic bit params_ok(input int order, input int r_log2, input int out_w);
    return (order >= 1) && (order <= 4) &&
           (r_log2 >= 2) && (r_log2 <= 8) &&
           (out_w >= 4) && (out_w <= order * r_log2);
  endfunction

endpackage

// File: rtl/cic_decimator_if.sv
// Control inputs and decimated/serial outputs of the CIC decimator.
interface cic_decimator_if #(
  parameter int OUT_W = 12
);
  logic             en;
  logic             data_in;
  logic             shift;
  logic [OUT_W-1:0] data_out;
  logic             new_data;
  logic             serial_data_out;
  logic             overrun;

  modport master (
    output en, data_in, shift,
    input  data_out, new_data, serial_data_out, overrun
  );

  modport slave (
    input  en, data_in, shift,
    output data_out, new_data, serial_data_out, overrun
  );
endinterface

// File: rtl/cic_serializer.sv
// MSB-first parallel-to-serial register; load has priority over shift, output valid the cycle after load.
// Loading while bits remain unread sets a sticky overrun flag.
module cic_serializer #(
  parameter int OUT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [OUT_W-1:0] load_dat,
  input  logic             shift,
  output logic             serial_out,
  output logic             overrun
);
  localparam int CNT_W = $clog2(OUT_W + 1);

  logic [OUT_W-1:0] sreg;
  logic [CNT_W-1:0] bits_left;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg      <= '0;
      bits_left <= '0;
      overrun   <= 1'b0;
    end else if (load) begin
      sreg      <= load_dat;
      bits_left <= CNT_W'(OUT_W);
      if (bits_left != '0) overrun <= 1'b1;
    end else if (shift && (bits_left != '0)) begin
      sreg      <= {sreg[OUT_W-2:0], 1'b0};
      bits_left <= bits_left - CNT_W'(1);
    end
  end

  assign serial_out = sreg[OUT_W-1];

endmodule

// File: rtl/cic_decimator.sv
// Sinc^ORDER decimator for a 1-bit stream: output registered on the decimation tick, new_data pulses the cycle after.
// No backpressure; en stalls the filter path, the serial readout keeps running.
module cic_decimator
  import cic_pkg::*;
#(
  parameter int ORDER  = 2,
  parameter int R_LOG2 = 6,
  parameter int OUT_W  = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  cic_decimator_if.slave bus
);
  localparam int ACC_W = acc_w(ORDER, R_LOG2);
  localparam int VW    = ORDER * R_LOG2;
  localparam logic [ACC_W-1:0] SAT = ACC_W'(sat_limit(ORDER, R_LOG2));
  localparam int WU_W  = $clog2(ORDER + 1);
  localparam logic [WU_W-1:0] WU_DONE = WU_W'(ORDER);

  if (!params_ok(ORDER, R_LOG2, OUT_W)) begin : g_param_check
    $error("cic_decimator: ORDER, R_LOG2 or OUT_W out of range");
  end

  logic [R_LOG2-1:0] dec_cnt;
  logic [WU_W-1:0]   warm_cnt;
  logic [OUT_W-1:0]  data_out_q;
  logic              new_data_q;
  logic              tick;

  assign tick = bus.en & (&dec_cnt);

  // Integrator cascade; every stage is registered, so stage k lags stage k-1 by one cycle.
  for (genvar k = 0; k < ORDER; k++) begin : g_int
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] addend;

    if (k == 0) begin : g_first
      assign addend = ACC_W'(bus.data_in);
    end else begin : g_rest
      assign addend = g_int[k-1].acc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      acc_q <= '0;
      else if (bus.en) acc_q <= acc_q + addend;
    end
  end

  // Comb chain is combinational across stages; only the delays are registered on ticks.
  for (genvar k = 1; k <= ORDER; k++) begin : g_comb
    logic [ACC_W-1:0] stage_in;
    logic [ACC_W-1:0] dly_q;
    logic [ACC_W-1:0] diff;

    if (k == 1) begin : g_first
      assign stage_in = g_int[ORDER-1].acc_q;
    end else begin : g_rest
      assign stage_in = g_comb[k-1].diff;
    end

    assign diff = stage_in - dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    dly_q <= '0;
      else if (tick) dly_q <= stage_in;
    end
  end

  logic [ACC_W-1:0] comb_out;
  logic [VW-1:0]    sat_val;
  logic [OUT_W-1:0] scaled;

  assign comb_out = g_comb[ORDER].diff;
  assign sat_val  = (comb_out > SAT) ? SAT[VW-1:0] : comb_out[VW-1:0];
  assign scaled   = OUT_W'(sat_val >> (VW - OUT_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt    <= '0;
      warm_cnt   <= '0;
      data_out_q <= '0;
      new_data_q <= 1'b0;
    end else begin
      new_data_q <= 1'b0;
      if (bus.en) dec_cnt <= dec_cnt + R_LOG2'(1);
      if (tick) begin
        if (warm_cnt != WU_DONE) begin
          warm_cnt <= warm_cnt + WU_W'(1);
        end else begin
          data_out_q <= scaled;
          new_data_q <= 1'b1;
        end
      end
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.new_data = new_data_q;

  cic_serializer #(
    .OUT_W (OUT_W)
  ) u_serializer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (new_data_q),
    .load_dat   (data_out_q),
    .shift      (bus.shift),
    .serial_out (bus.serial_data_out),
    .overrun    (bus.overrun)
  );

endmodule

// File: tb/tb_cic_decimator.sv
// Directed bench for cic_decimator at ORDER=2, R_LOG2=6, OUT_W=12.
module tb_cic_decimator;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  int   edge_n;
  int   pattern;
  logic alt_bit;

  cic_decimator_if #(.OUT_W(12)) bus ();

  cic_decimator #(
    .ORDER  (2),
    .R_LOG2 (6),
    .OUT_W  (12)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic next_bit();
    if (pattern == 0) return 1'b0;
    if (pattern == 1) return 1'b1;
    alt_bit = ~alt_bit;
    return alt_bit;
  endfunction

  // One clock edge; outputs are sampled afterwards on the falling edge.
  task automatic step();
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    bus.data_in = next_bit();
  endtask

  task automatic do_reset(input int pat);
    rst_n    = 1'b0;
    bus.en   = 1'b1;
    bus.shift = 1'b0;
    bus.data_in = 1'b0;
    pattern  = pat;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    edge_n  = 0;
    alt_bit = 1'b1;
    bus.data_in = (pat == 0) ? 1'b0 : 1'b1;
  endtask

  task automatic wait_new_data(input int limit, output int at_edge);
    at_edge = -1;
    for (int i = 0; i < limit; i++) begin
      step();
      if (bus.new_data === 1'b1) begin
        at_edge = edge_n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.en = 1'b1;
    bus.shift = 1'b0;
    bus.data_in = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.data_out !== 12'h000) begin n_bad++; $display("FAIL reset_data_out: got %h expected 000", bus.data_out); end
    n_cmp++; if (bus.new_data !== 1'b0) begin n_bad++; $display("FAIL reset_new_data: got %b expected 0", bus.new_data); end
    n_cmp++; if (bus.serial_data_out !== 1'b0) begin n_bad++; $display("FAIL reset_serial: got %b expected 0", bus.serial_data_out); end
    n_cmp++; if (bus.overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b expected 0", bus.overrun); end
  endtask

  task automatic test_zeros();
    int e;
    do_reset(0);
    wait_new_data(300, e);
    n_cmp++; if (e !== 192) begin n_bad++; $display("FAIL zeros_first_edge: got %0d expected 192", e); end
    n_cmp++; if (bus.data_out !== 12'h000) begin n_bad++; $display("FAIL zeros_value: got %h expected 000", bus.data_out); end
    step();
    n_cmp++; if (bus.new_data !== 1'b0) begin n_bad++; $display("FAIL zeros_pulse_width: got %b expected 0", bus.new_data); end
    wait_new_data(100, e);
    n_cmp++; if (e !== 256) begin n_bad++; $display("FAIL zeros_second_edge: got %0d expected 256", e); end
    wait_new_data(100, e);
    n_cmp++; if (e !== 320) begin n_bad++; $display("FAIL zeros_third_edge: got %0d expected 320", e); end
  endtask

  task automatic test_ones();
    int e;
    do_reset(1);
    wait_new_data(300, e);
    n_cmp++; if (e !== 192) begin n_bad++; $display("FAIL ones_first_edge: got %0d expected 192", e); end
    n_cmp++; if (bus.data_out !== 12'hFFF) begin n_bad++; $display("FAIL ones_sat_first: got %h expected FFF", bus.data_out); end
    for (int i = 0; i < 3; i++) begin
      wait_new_data(100, e);
      n_cmp++; if (bus.data_out !== 12'hFFF) begin n_bad++; $display("FAIL ones_sat_%0d: got %h expected FFF", i, bus.data_out); end
    end
  endtask

  task automatic test_alternating();
    int e;
    int prev;
    do_reset(2);
    wait_new_data(300, e);
    n_cmp++; if (e !== 192) begin n_bad++; $display("FAIL alt_first_edge: got %0d expected 192", e); end
    n_cmp++; if (bus.data_out !== 12'h800) begin n_bad++; $display("FAIL alt_first_value: got %h expected 800", bus.data_out); end
    prev = e;
    while (edge_n < 8400) begin
      wait_new_data(100, e);
      n_cmp++; if (e !== prev + 64) begin n_bad++; $display("FAIL alt_period: got edge %0d expected %0d", e, prev + 64); end
      n_cmp++; if (bus.data_out !== 12'h800) begin n_bad++; $display("FAIL alt_value at edge %0d: got %h expected 800", e, bus.data_out); end
      if (e < 0) break;
      prev = e;
    end
  endtask

  task automatic test_en_gap();
    int e;
    do_reset(1);
    wait_new_data(300, e);
    n_cmp++; if (e !== 192) begin n_bad++; $display("FAIL gap_first_edge: got %0d expected 192", e); end
    repeat (10) step();
    bus.en = 1'b0;
    repeat (37) step();
    bus.en = 1'b1;
    wait_new_data(200, e);
    n_cmp++; if (e !== 293) begin n_bad++; $display("FAIL gap_delayed_edge: got %0d expected 293", e); end
    n_cmp++; if (bus.data_out !== 12'hFFF) begin n_bad++; $display("FAIL gap_value: got %h expected FFF", bus.data_out); end
    wait_new_data(100, e);
    n_cmp++; if (e !== 357) begin n_bad++; $display("FAIL gap_next_edge: got %0d expected 357", e); end
  endtask

  task automatic test_readout();
    int e;
    logic [11:0] word;
    do_reset(2);
    wait_new_data(300, e);
    n_cmp++; if (e !== 192) begin n_bad++; $display("FAIL rd_first_edge: got %0d expected 192", e); end
    // shift asserted together with new_data: that shift must be dropped
    bus.shift = 1'b1;
    word = '0;
    step();
    n_cmp++; if (bus.serial_data_out !== 1'b1) begin n_bad++; $display("FAIL rd_load_wins: got %b expected 1", bus.serial_data_out); end
    word = {word[10:0], bus.serial_data_out};
    for (int i = 0; i < 11; i++) begin
      step();
      word = {word[10:0], bus.serial_data_out};
    end
    step();
    bus.shift = 1'b0;
    n_cmp++; if (word !== 12'h800) begin n_bad++; $display("FAIL rd_word: got %h expected 800", word); end
    n_cmp++; if (bus.serial_data_out !== 1'b0) begin n_bad++; $display("FAIL rd_drained: got %b expected 0", bus.serial_data_out); end
    wait_new_data(100, e);
    step();
    n_cmp++; if (bus.overrun !== 1'b0) begin n_bad++; $display("FAIL rd_no_overrun: got %b expected 0", bus.overrun); end
    n_cmp++; if (bus.serial_data_out !== 1'b1) begin n_bad++; $display("FAIL rd_reload_msb: got %b expected 1", bus.serial_data_out); end
    bus.shift = 1'b1;
    repeat (5) step();
    bus.shift = 1'b0;
    wait_new_data(100, e);
    n_cmp++; if (bus.overrun !== 1'b0) begin n_bad++; $display("FAIL rd_overrun_early: got %b expected 0", bus.overrun); end
    step();
    n_cmp++; if (bus.overrun !== 1'b1) begin n_bad++; $display("FAIL rd_overrun_set: got %b expected 1", bus.overrun); end
    bus.shift = 1'b1;
    repeat (20) step();
    bus.shift = 1'b0;
    wait_new_data(100, e);
    step();
    n_cmp++; if (bus.overrun !== 1'b1) begin n_bad++; $display("FAIL rd_overrun_sticky: got %b expected 1", bus.overrun); end
  endtask

  task automatic test_reset_mid();
    int e;
    do_reset(1);
    wait_new_data(300, e);
    wait_new_data(100, e);
    step();
    bus.shift = 1'b1;
    repeat (3) step();
    bus.shift = 1'b0;
    n_cmp++; if (bus.overrun !== 1'b1) begin n_bad++; $display("FAIL mid_pre_overrun: got %b expected 1", bus.overrun); end
    n_cmp++; if (bus.serial_data_out !== 1'b1) begin n_bad++; $display("FAIL mid_pre_serial: got %b expected 1", bus.serial_data_out); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.data_out !== 12'h000) begin n_bad++; $display("FAIL mid_data_out: got %h expected 000", bus.data_out); end
    n_cmp++; if (bus.new_data !== 1'b0) begin n_bad++; $display("FAIL mid_new_data: got %b expected 0", bus.new_data); end
    n_cmp++; if (bus.serial_data_out !== 1'b0) begin n_bad++; $display("FAIL mid_serial: got %b expected 0", bus.serial_data_out); end
    n_cmp++; if (bus.overrun !== 1'b0) begin n_bad++; $display("FAIL mid_overrun: got %b expected 0", bus.overrun); end
    do_reset(1);
    wait_new_data(300, e);
    n_cmp++; if (e !== 192) begin n_bad++; $display("FAIL mid_restart_edge: got %0d expected 192", e); end
    n_cmp++; if (bus.data_out !== 12'hFFF) begin n_bad++; $display("FAIL mid_restart_value: got %h expected FFF", bus.data_out); end
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    edge_n  = 0;
    pattern = 0;
    alt_bit = 1'b0;
    test_reset();
    test_zeros();
    test_ones();
    test_alternating();
    test_en_gap();
    test_readout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
